// File: rtl/conv_out_pkg.sv
// Shared types and sizing helpers for the output FIFO scheduler.
package conv_out_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int FRAME_W       = 16;
  localparam int DEPTH_DEFAULT = 1024;

  // Occupancy must represent 0..depth inclusive, hence one extra bit.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int OCC_W = occ_width(DEPTH_DEFAULT);

endpackage

// File: rtl/output_fifo_sched_if.sv
// Pixel-in / packed-word-out handshake bundle of the output FIFO scheduler.
// master = the scheduler, slave = the conv core / readout side.
interface output_fifo_sched_if #(
  parameter int W    = 8,
  parameter int PACK = 4
);
  logic [W-1:0]      pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [PACK*W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              word_last;

  modport master (
    input  pix_data, pix_valid, word_ready,
    output pix_ready, word_data, word_valid, word_last
  );

  modport slave (
    output pix_data, pix_valid, word_ready,
    input  pix_ready, word_data, word_valid, word_last
  );
endinterface

// File: rtl/out_word_packer.sv
// Collects FIFO read data into PACK lanes and hands complete words to a
// valid/ready word register. A completed assembly is merged straight into
// the word register when it is free; otherwise it is parked and asm_full
// tells the scheduler to stop issuing reads.
module out_word_packer #(
  parameter int W    = 8,
  parameter int PACK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_vld,
  input  logic [W-1:0]      cap_data,
  input  logic              cap_last,
  input  logic              word_ready,
  output logic [PACK*W-1:0] word_data,
  output logic              word_valid,
  output logic              word_last,
  output logic              asm_full
);

  localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int CW = LW + 1;
  localparam logic [LW-1:0] LANE_LAST = LW'(PACK - 1);

  logic [W-1:0]      lane_q [PACK];
  logic [LW-1:0]     lane_idx;
  logic [CW-1:0]     asm_cnt;
  logic [CW-1:0]     src_cnt;
  logic              asm_pend;
  logic              asm_last;
  logic              word_free;
  logic              complete;
  logic              ld_word;
  logic              ld_last;
  logic [PACK*W-1:0] asm_word;

  assign asm_full = asm_pend;

  // Build the candidate word: filled lanes (including a pixel arriving now), unused lanes zero.
  always_comb begin
    word_free = !word_valid || word_ready;
    complete  = cap_vld && ((lane_idx == LANE_LAST) || cap_last);
    ld_word   = (complete || asm_pend) && word_free;
    ld_last   = asm_pend ? asm_last : cap_last;
    src_cnt   = asm_pend ? asm_cnt : (CW'(lane_idx) + 1'b1);
    asm_word  = '0;
    for (int i = 0; i < PACK; i++) begin
      if (CW'(i) < src_cnt) begin
        if (cap_vld && (lane_idx == LW'(i))) asm_word[i*W +: W] = cap_data;
        else                                 asm_word[i*W +: W] = lane_q[i];
      end
    end
  end

  // Lane storage; stale lanes are masked by the fill count, so no reset needed.
  always_ff @(posedge clk) begin
    if (cap_vld) lane_q[lane_idx] <= cap_data;
  end

  // Lane pointer and parked-assembly bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_idx <= '0;
      asm_pend <= 1'b0;
      asm_last <= 1'b0;
      asm_cnt  <= '0;
    end else begin
      if (asm_pend && word_free) asm_pend <= 1'b0;
      if (cap_vld) begin
        if (complete) begin
          lane_idx <= '0;
          if (!word_free) begin
            asm_pend <= 1'b1;
            asm_last <= cap_last;
            asm_cnt  <= CW'(lane_idx) + 1'b1;
          end
        end else begin
          lane_idx <= lane_idx + 1'b1;
        end
      end
    end
  end

  // Output word register: held stable until the consumer accepts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_valid <= 1'b0;
      word_last  <= 1'b0;
      word_data  <= '0;
    end else if (ld_word) begin
      word_valid <= 1'b1;
      word_last  <= ld_last;
      word_data  <= asm_word;
    end else if (word_ready) begin
      word_valid <= 1'b0;
      word_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/output_fifo_sched.sv
// Time-shares the single-op-per-cycle output FIFO between the conv pixel
// stream (writes) and the readout packer (reads), frames the stream by a
// pixel count and cross-checks the FIFO empty flag against occupancy.
module output_fifo_sched
  import conv_out_pkg::*;
#(
  parameter int W            = 8,
  parameter int DEPTH        = DEPTH_DEFAULT,
  parameter int PACK         = 4,
  parameter int MAX_WR_BURST = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame_len,
  output_fifo_sched_if.master bus,
  output logic [W-1:0]       fifo_wr_data,
  output logic               fifo_wr_en,
  output logic               fifo_rd_en,
  input  logic [W-1:0]       fifo_rd_data,
  input  logic               fifo_empty,
  output logic               busy,
  output logic               done,
  output logic               sync_err
);

  localparam int OW = (DEPTH == DEPTH_DEFAULT) ? OCC_W : occ_width(DEPTH);
  localparam int BW = $clog2(MAX_WR_BURST + 1);
  localparam logic [OW-1:0] OCC_FULL  = OW'(DEPTH);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_WR_BURST);

  state_t             state, state_nx;
  logic [FRAME_W-1:0] len_q;
  logic [FRAME_W-1:0] wc;
  logic [FRAME_W-1:0] ri;
  logic [FRAME_W-1:0] rc;
  logic [OW-1:0]      occ;
  logic [BW-1:0]      burst;
  logic               rd_vld_p1;
  logic               op_p1;
  logic               sync_err_q;
  logic               asm_full;
  logic               run;
  logic               wr_ok;
  logic               rd_pend;
  logic               rd_req;
  logic               rd_grant;
  logic               pix_rdy;
  logic               wr_fire;
  logic               cap_last;
  logic               final_hs;

  function automatic logic [BW-1:0] burst_sat_inc(input logic [BW-1:0] b);
    return (b >= BURST_MAX) ? b : b + 1'b1;
  endfunction

  // Arbitration: a write wins unless the write burst limit is hit while a read waits.
  // The burst window treats a read in flight as still pending so the period is burst+1.
  always_comb begin
    wr_ok    = run && (wc < len_q) && (occ < OCC_FULL);
    rd_pend  = run && (occ != '0) && (ri < len_q) && !asm_full;
    rd_req   = rd_pend && !rd_vld_p1;
    rd_grant = rd_req && (!(wr_ok && bus.pix_valid) || (burst >= BURST_MAX));
    pix_rdy  = wr_ok && !rd_grant;
    wr_fire  = bus.pix_valid && pix_rdy;
    cap_last = (rc == (len_q - 1'b1));
    final_hs = bus.word_valid && bus.word_ready && bus.word_last;
  end

  assign bus.pix_ready = pix_rdy;
  assign fifo_wr_en    = wr_fire;
  assign fifo_wr_data  = bus.pix_data;
  assign fifo_rd_en    = rd_grant;
  assign sync_err      = sync_err_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next-state logic; start only acts from IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN: begin
        if (final_hs)           state_nx = DONE;
        else if (rc == len_q)   state_nx = FLUSH;
      end
      FLUSH: if (final_hs) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    run  = (state == RUN);
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Frame length latch and write / read-issue / read-capture counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= '0;
      wc    <= '0;
      ri    <= '0;
      rc    <= '0;
    end else if ((state == IDLE) && start) begin
      len_q <= (frame_len == '0) ? FRAME_W'(1) : frame_len;
      wc    <= '0;
      ri    <= '0;
      rc    <= '0;
    end else begin
      if (wr_fire)   wc <= wc + 1'b1;
      if (rd_grant)  ri <= ri + 1'b1;
      if (rd_vld_p1) rc <= rc + 1'b1;
    end
  end

  // FIFO occupancy; write and read are mutually exclusive by construction.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
    end else begin
      case ({wr_fire, rd_grant})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Consecutive-write counter while a read is waiting.
  always_ff @(posedge clk) begin
    if (rst)                        burst <= '0;
    else if (rd_grant || !rd_pend)  burst <= '0;
    else if (wr_fire)               burst <= burst_sat_inc(burst);
  end

  // ---- stage p1: FIFO read data returns one cycle after fifo_rd_en ----
  // Read-in-flight flag and previous-cycle activity for the empty-flag check.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_p1 <= 1'b0;
      op_p1     <= 1'b0;
    end else begin
      rd_vld_p1 <= rd_grant;
      op_p1     <= wr_fire || rd_grant;
    end
  end

  // Sticky flag: FIFO empty disagrees with occupancy in a settled cycle.
  always_ff @(posedge clk) begin
    if (rst)
      sync_err_q <= 1'b0;
    else if (!op_p1 && (fifo_empty != (occ == '0)))
      sync_err_q <= 1'b1;
  end

  out_word_packer #(
    .W    (W),
    .PACK (PACK)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .cap_vld    (rd_vld_p1),
    .cap_data   (fifo_rd_data),
    .cap_last   (cap_last),
    .word_ready (bus.word_ready),
    .word_data  (bus.word_data),
    .word_valid (bus.word_valid),
    .word_last  (bus.word_last),
    .asm_full   (asm_full)
  );

endmodule

// File: tb/tb_output_fifo_sched.sv
// Directed bench for output_fifo_sched with a behavioural output FIFO.
module tb_output_fifo_sched;

  localparam int W     = 8;
  localparam int PACK  = 4;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] frame_len;
  logic [W-1:0] fifo_wr_data;
  logic        fifo_wr_en;
  logic        fifo_rd_en;
  logic [W-1:0] fifo_rd_data;
  logic        fifo_empty;
  logic        busy;
  logic        done;
  logic        sync_err;

  output_fifo_sched_if #(.W(W), .PACK(PACK)) bus ();

  output_fifo_sched #(
    .W(W), .DEPTH(DEPTH), .PACK(PACK), .MAX_WR_BURST(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .frame_len    (frame_len),
    .bus          (bus),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .busy         (busy),
    .done         (done),
    .sync_err     (sync_err)
  );

  always #5 clk = ~clk;

  // Behavioural output FIFO.
  logic [W-1:0] fq[$];
  int  fifo_cnt = 0;
  int  ovf = 0;
  int  unf = 0;
  bit  empty_flip = 1'b0;

  assign fifo_empty = (fifo_cnt == 0) ^ empty_flip;

  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      fifo_cnt     <= 0;
      fifo_rd_data <= '0;
    end else begin
      if (fifo_wr_en) begin
        if (fq.size() >= DEPTH) ovf <= ovf + 1;
        fq.push_back(fifo_wr_data);
      end
      if (fifo_rd_en) begin
        if (fq.size() == 0) unf <= unf + 1;
        else fifo_rd_data <= fq.pop_front();
      end
      fifo_cnt <= fq.size();
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int overlap = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_hs_cyc = 0;
  int hold_bad = 0;
  int ngr = 0;
  int gr_cyc [9];
  int src_base = 0;
  int src_idx = 0;
  bit prev_hold = 1'b0;
  logic [PACK*W-1:0] prev_word = '0;
  logic [PACK*W-1:0] rxw[$];
  bit rxl[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample on the falling edge, update inputs just after the rising edge.
  task automatic step();
    bit pix_acc;
    @(negedge clk);
    if (fifo_wr_en && fifo_rd_en) overlap++;
    if (fifo_rd_en) begin
      if (ngr < 9) gr_cyc[ngr] = cyc;
      ngr++;
    end
    if (prev_hold && !rst && (!bus.word_valid || bus.word_data !== prev_word)) hold_bad++;
    prev_hold = bus.word_valid && !bus.word_ready;
    prev_word = bus.word_data;
    pix_acc = bus.pix_valid && bus.pix_ready;
    if (bus.word_valid && bus.word_ready) begin
      rxw.push_back(bus.word_data);
      rxl.push_back(bus.word_last);
      if (bus.word_last) last_hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (pix_acc) begin
      src_idx++;
      bus.pix_data = W'(src_base + src_idx);
    end
    cyc++;
  endtask

  // Run one frame and compare every received word with the expected packing.
  task automatic run_frame(input string tag, input int len, input int base,
                           input int hold, input int restart_at);
    int eff;
    int nw;
    int n;
    int last_bad;
    logic [PACK*W-1:0] exp_w;
    eff = (len == 0) ? 1 : len;
    rxw.delete();
    rxl.delete();
    done_cnt = 0;
    overlap  = 0;
    src_base = base;
    src_idx  = 0;
    bus.pix_data   = W'(base);
    bus.pix_valid  = 1'b1;
    bus.word_ready = (hold == 0);
    frame_len = 16'(len);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 20000) begin
      if (hold > 0 && n == hold) begin
        check_val({tag, "_occ_full"}, fifo_cnt, DEPTH);
        check_val({tag, "_pix_ready_full"}, bus.pix_ready, 1'b0);
        bus.word_ready = 1'b1;
      end
      if (n == restart_at) begin
        check_val({tag, "_busy_at_restart"}, busy, 1'b1);
        frame_len = 16'd5;
      end
      start = (n == restart_at);
      step();
      n++;
    end
    start = 1'b0;
    check_val({tag, "_done_seen"}, done_cnt > 0, 1'b1);
    repeat (3) step();
    check_val({tag, "_done_pulse"}, done_cnt, 1);
    check_val({tag, "_done_latency"}, done_cyc - last_hs_cyc, 1);
    nw = (eff + PACK - 1) / PACK;
    check_val({tag, "_nwords"}, rxw.size(), nw);
    last_bad = 0;
    for (int w = 0; w < nw && w < rxw.size(); w++) begin
      exp_w = '0;
      for (int j = 0; j < PACK; j++) begin
        if (w * PACK + j < eff) exp_w[j*W +: W] = W'(base + w * PACK + j);
      end
      check_val($sformatf("%s_word%0d", tag, w), rxw[w], exp_w);
      if (rxl[w] != (w == nw - 1)) last_bad++;
    end
    check_val({tag, "_last_flags"}, last_bad, 0);
    check_val({tag, "_overlap"}, overlap, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    frame_len = '0;
    bus.pix_data   = '0;
    bus.pix_valid  = 1'b0;
    bus.word_ready = 1'b0;
    repeat (3) step();
    check_val("rst_busy",       busy, 1'b0);
    check_val("rst_done",       done, 1'b0);
    check_val("rst_word_valid", bus.word_valid, 1'b0);
    check_val("rst_word_data",  bus.word_data, '0);
    check_val("rst_word_last",  bus.word_last, 1'b0);
    check_val("rst_pix_ready",  bus.pix_ready, 1'b0);
    check_val("rst_rd_en",      fifo_rd_en, 1'b0);
    check_val("rst_sync_err",   sync_err, 1'b0);
    rst = 1'b0;
    step();

    // 1: eight pixels, two full words
    run_frame("t1", 8, 'h00, 0, -1);
    check_val("t1_w0_const", rxw[0], 32'h03020100);
    check_val("t1_w1_const", rxw[1], 32'h07060504);

    // 2: six pixels, second word has two zero lanes
    run_frame("t2", 6, 'h10, 0, -1);
    check_val("t2_w1_const", rxw[1], 32'h00001514);
    check_val("t2_w1_last", rxl[1], 1'b1);

    // frame_len 0 behaves as a single pixel
    run_frame("t0", 0, 'h55, 0, -1);
    check_val("t0_w0_const", rxw[0], 32'h00000055);

    // 3: read grant period under continuous writes
    ngr = 0;
    foreach (gr_cyc[k]) gr_cyc[k] = 0;
    run_frame("t3", 200, 'h20, 0, -1);
    for (int k = 1; k < 9; k++)
      check_val($sformatf("t3_gap%0d", k), gr_cyc[k] - gr_cyc[k-1], 17);

    // 4: consumer stalls until the FIFO fills
    hold_bad = 0;
    run_frame("t4", 2000, 'h00, 1500, -1);
    check_val("t4_word_hold", hold_bad, 0);

    // 5: reset in the middle of a frame, then a short frame
    rxw.delete();
    rxl.delete();
    src_base = 'h40;
    src_idx  = 0;
    bus.pix_data   = 8'h40;
    bus.pix_valid  = 1'b1;
    bus.word_ready = 1'b1;
    frame_len = 16'd100;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (src_idx < 37 && n < 500) begin
      step();
      n++;
    end
    check_val("t5_reached_37", src_idx, 37);
    rst = 1'b1;
    step();
    step();
    check_val("t5_rst_busy",       busy, 1'b0);
    check_val("t5_rst_word_valid", bus.word_valid, 1'b0);
    check_val("t5_rst_pix_ready",  bus.pix_ready, 1'b0);
    check_val("t5_rst_rd_en",      fifo_rd_en, 1'b0);
    rst = 1'b0;
    done_cnt = 0;
    repeat (3) step();
    check_val("t5_no_done_after_abort", done_cnt, 0);
    run_frame("t5", 4, 'hA0, 0, -1);
    check_val("t5_w0_const", rxw[0], 32'hA3A2A1A0);

    // 6: start while busy is ignored; empty-flag disagreement is sticky
    run_frame("t6", 40, 'h80, 0, 10);
    check_val("t6_sync_clean", sync_err, 1'b0);
    empty_flip = 1'b1;
    step();
    step();
    check_val("t6_sync_set", sync_err, 1'b1);
    empty_flip = 1'b0;
    step();
    check_val("t6_sync_sticky", sync_err, 1'b1);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_val("t6_sync_rst", sync_err, 1'b0);

    check_val("fifo_overflow",  ovf, 0);
    check_val("fifo_underflow", unf, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
